// File: rtl/xy_switch_allocator_if.sv
// Handshake bundle between the XY router datapath and its per-output switch allocator.
// The allocator connects through the slave modport; the router side uses master.
interface xy_switch_allocator_if #(
  parameter int IN_N       = 5,
  parameter int OUT_N      = 5,
  parameter int OUTPUT_N_W = 3,
  parameter int IN_N_W     = 3
) ();
  logic [IN_N-1:0]            in_valid_i;
  logic [IN_N-1:0]            in_head_i;
  logic [IN_N-1:0]            in_tail_i;
  logic [IN_N*OUTPUT_N_W-1:0] in_out_sel_i;
  logic [IN_N-1:0]            in_ready_o;
  logic [OUT_N-1:0]           out_ready_i;
  logic [OUT_N-1:0]           out_valid_o;
  logic [OUT_N*IN_N_W-1:0]    out_in_sel_o;
  logic [OUT_N-1:0]           out_busy_o;

  modport master (
    output in_valid_i, in_head_i, in_tail_i, in_out_sel_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_in_sel_o, out_busy_o
  );

  modport slave (
    input  in_valid_i, in_head_i, in_tail_i, in_out_sel_i, out_ready_i,
    output in_ready_o, out_valid_o, out_in_sel_o, out_busy_o
  );
endinterface

// File: rtl/xy_switch_allocator.sv
// Per-output wormhole switch allocator for a 5-port XY mesh router: round-robin
// grant on head flits, lock held until the tail flit transfers.
module xy_switch_allocator #(
  parameter int IN_N       = 5,
  parameter int OUT_N      = 5,
  parameter int OUTPUT_N_W = 3,
  parameter int IN_N_W     = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  xy_switch_allocator_if.slave  bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e            state_r    [OUT_N];
  state_e            state_nx_s [OUT_N];
  logic [IN_N_W-1:0] own_r      [OUT_N];
  logic [IN_N_W-1:0] own_nx_s   [OUT_N];
  logic [IN_N_W-1:0] ptr_r      [OUT_N];
  logic [IN_N_W-1:0] ptr_nx_s   [OUT_N];
  logic [IN_N-1:0]   req_s      [OUT_N];
  logic [IN_N_W-1:0] win_s      [OUT_N];

  logic [IN_N-1:0]         owns_s;
  logic [OUT_N-1:0]        locked_s;
  logic [OUT_N-1:0]        xfer_s;
  logic [OUT_N-1:0]        tail_s;
  logic [IN_N-1:0]         in_ready_s;
  logic [OUT_N-1:0]        out_valid_s;
  logic [OUT_N-1:0]        out_busy_s;
  logic [OUT_N*IN_N_W-1:0] out_in_sel_s;

  // First requester strictly after ptr, wrapping modulo IN_N (ptr is always < IN_N).
  function automatic logic [IN_N_W-1:0] rr_pick(input logic [IN_N-1:0] req,
                                                input logic [IN_N_W-1:0] ptr);
    logic [IN_N_W-1:0] win;
    logic [IN_N_W:0]   cand;
    logic              hit;
    win  = '0;
    hit  = 1'b0;
    cand = '0;
    for (int k = 1; k <= IN_N; k++) begin
      cand = {1'b0, ptr} + (IN_N_W + 1)'(k);
      if (cand >= (IN_N_W + 1)'(IN_N)) begin
        cand = cand - (IN_N_W + 1)'(IN_N);
      end else begin
        cand = cand;
      end
      if (!hit && req[cand[IN_N_W-1:0]]) begin
        win = cand[IN_N_W-1:0];
        hit = 1'b1;
      end else begin
        win = win;
      end
    end
    return win;
  endfunction

  // Per-output lock status and whether the owning input moves a flit this cycle.
  always_comb begin
    locked_s = '0;
    xfer_s   = '0;
    tail_s   = '0;
    for (int o = 0; o < OUT_N; o++) begin
      locked_s[o] = (state_r[o] == LOCKED);
      xfer_s[o]   = locked_s[o] & bus.in_valid_i[own_r[o]] & bus.out_ready_i[o];
      tail_s[o]   = bus.in_tail_i[own_r[o]];
    end
  end

  // An input already streaming a packet must not compete for another output.
  always_comb begin
    owns_s = '0;
    for (int i = 0; i < IN_N; i++) begin
      for (int o = 0; o < OUT_N; o++) begin
        if (locked_s[o] && (own_r[o] == IN_N_W'(i))) begin
          owns_s[i] = 1'b1;
        end else begin
          owns_s[i] = owns_s[i];
        end
      end
    end
  end

  // Head-flit requests per output; out-of-range codes match no output.
  always_comb begin
    for (int o = 0; o < OUT_N; o++) begin
      req_s[o] = '0;
      for (int i = 0; i < IN_N; i++) begin
        req_s[o][i] = bus.in_valid_i[i] & bus.in_head_i[i] & ~owns_s[i] &
                      (bus.in_out_sel_i[i*OUTPUT_N_W +: OUTPUT_N_W] == OUTPUT_N_W'(o));
      end
      win_s[o] = rr_pick(req_s[o], ptr_r[o]);
    end
  end

  // Allocation state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int o = 0; o < OUT_N; o++) begin
        state_r[o] <= IDLE;
        own_r[o]   <= '0;
        ptr_r[o]   <= IN_N_W'(IN_N - 1);
      end
    end else begin
      for (int o = 0; o < OUT_N; o++) begin
        state_r[o] <= state_nx_s[o];
        own_r[o]   <= own_nx_s[o];
        ptr_r[o]   <= ptr_nx_s[o];
      end
    end
  end

  // Next-state logic: grant on IDLE, release when the tail flit transfers.
  always_comb begin
    for (int o = 0; o < OUT_N; o++) begin
      state_nx_s[o] = state_r[o];
      own_nx_s[o]   = own_r[o];
      ptr_nx_s[o]   = ptr_r[o];
      case (state_r[o])
        IDLE: begin
          if (|req_s[o]) begin
            state_nx_s[o] = LOCKED;
            own_nx_s[o]   = win_s[o];
            ptr_nx_s[o]   = win_s[o];
          end else begin
            state_nx_s[o] = IDLE;
          end
        end
        LOCKED: begin
          if (xfer_s[o] && tail_s[o]) begin
            state_nx_s[o] = IDLE;
          end else begin
            state_nx_s[o] = LOCKED;
          end
        end
        default: begin
          state_nx_s[o] = IDLE;
        end
      endcase
    end
  end

  // Crossbar select and handshakes, decoded from the registered lock state.
  always_comb begin
    in_ready_s   = '0;
    out_valid_s  = '0;
    out_busy_s   = '0;
    out_in_sel_s = '0;
    for (int o = 0; o < OUT_N; o++) begin
      out_in_sel_s[o*IN_N_W +: IN_N_W] = own_r[o];
      if (locked_s[o]) begin
        out_busy_s[o]  = 1'b1;
        out_valid_s[o] = bus.in_valid_i[own_r[o]];
      end else begin
        out_busy_s[o]  = 1'b0;
        out_valid_s[o] = 1'b0;
      end
    end
    for (int i = 0; i < IN_N; i++) begin
      for (int o = 0; o < OUT_N; o++) begin
        if (locked_s[o] && (own_r[o] == IN_N_W'(i)) && bus.out_ready_i[o]) begin
          in_ready_s[i] = 1'b1;
        end else begin
          in_ready_s[i] = in_ready_s[i];
        end
      end
    end
  end

  assign bus.in_ready_o   = in_ready_s;
  assign bus.out_valid_o  = out_valid_s;
  assign bus.out_busy_o   = out_busy_s;
  assign bus.out_in_sel_o = out_in_sel_s;

endmodule

// File: tb/tb_xy_switch_allocator.sv
// Self-checking bench for xy_switch_allocator: directed scenarios plus randomized
// traffic compared each cycle against a behavioural per-output lock model.
module tb_xy_switch_allocator;
  localparam int IN_N  = 5;
  localparam int OUT_N = 5;
  localparam int OW    = 3;
  localparam int IW    = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  xy_switch_allocator_if #(.IN_N(IN_N), .OUT_N(OUT_N), .OUTPUT_N_W(OW), .IN_N_W(IW)) bus ();

  xy_switch_allocator #(.IN_N(IN_N), .OUT_N(OUT_N), .OUTPUT_N_W(OW), .IN_N_W(IW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  bit m_locked [OUT_N];
  int m_owner  [OUT_N];
  int m_ptr    [OUT_N];
  int xfers    [IN_N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.in_valid_i   = '0;
    bus.in_head_i    = '0;
    bus.in_tail_i    = '0;
    bus.in_out_sel_i = '0;
  endtask

  task automatic set_in(input int i, input bit v, input bit h, input bit t, input int sel);
    bus.in_valid_i[i]          = v;
    bus.in_head_i[i]           = h;
    bus.in_tail_i[i]           = t;
    bus.in_out_sel_i[i*OW +: OW] = OW'(sel);
  endtask

  task automatic model_reset();
    for (int o = 0; o < OUT_N; o++) begin
      m_locked[o] = 1'b0;
      m_owner[o]  = 0;
      m_ptr[o]    = IN_N - 1;
    end
  endtask

  function automatic logic [IW-1:0] sel_of(input int o);
    logic [OUT_N*IW-1:0] v;
    v = bus.out_in_sel_o;
    return v[o*IW +: IW];
  endfunction

  task automatic model_check();
    logic [IN_N-1:0]     e_ready;
    logic [OUT_N-1:0]    e_valid;
    logic [OUT_N-1:0]    e_busy;
    logic [OUT_N*IW-1:0] e_sel;
    e_ready = '0;
    e_valid = '0;
    e_busy  = '0;
    e_sel   = '0;
    for (int o = 0; o < OUT_N; o++) begin
      e_busy[o] = m_locked[o];
      e_valid[o] = m_locked[o] && bus.in_valid_i[m_owner[o]];
      e_sel[o*IW +: IW] = IW'(m_owner[o]);
      if (m_locked[o] && bus.out_ready_i[o]) e_ready[m_owner[o]] = 1'b1;
    end
    chk("model_in_ready",   32'(bus.in_ready_o),   32'(e_ready));
    chk("model_out_valid",  32'(bus.out_valid_o),  32'(e_valid));
    chk("model_out_busy",   32'(bus.out_busy_o),   32'(e_busy));
    chk("model_out_in_sel", 32'(bus.out_in_sel_o), 32'(e_sel));
  endtask

  // Apply the allocation rules to the inputs present at the edge just taken.
  task automatic model_update(input logic [IN_N-1:0] v, input logic [IN_N-1:0] h,
                              input logic [IN_N-1:0] t, input logic [IN_N*OW-1:0] s,
                              input logic [OUT_N-1:0] r);
    bit owns [IN_N];
    for (int i = 0; i < IN_N; i++) owns[i] = 1'b0;
    for (int o = 0; o < OUT_N; o++) if (m_locked[o]) owns[m_owner[o]] = 1'b1;
    for (int o = 0; o < OUT_N; o++) begin
      if (m_locked[o]) begin
        if (v[m_owner[o]] && r[o]) begin
          xfers[m_owner[o]]++;
          if (t[m_owner[o]]) m_locked[o] = 1'b0;
        end
      end else begin
        int best, bestd, d;
        best = -1;
        bestd = IN_N;
        for (int i = 0; i < IN_N; i++) begin
          if (v[i] && h[i] && !owns[i] && int'(s[i*OW +: OW]) == o) begin
            d = (i - m_ptr[o] - 1 + 2 * IN_N) % IN_N;
            if (d < bestd) begin
              bestd = d;
              best  = i;
            end
          end
        end
        if (best >= 0) begin
          m_locked[o] = 1'b1;
          m_owner[o]  = best;
          m_ptr[o]    = best;
        end
      end
    end
  endtask

  task automatic tick();
    logic [IN_N-1:0]    v, h, t;
    logic [IN_N*OW-1:0] s;
    logic [OUT_N-1:0]   r;
    model_check();
    v = bus.in_valid_i;
    h = bus.in_head_i;
    t = bus.in_tail_i;
    s = bus.in_out_sel_i;
    r = bus.out_ready_i;
    @(posedge clk);
    model_update(v, h, t, s, r);
    #1;
  endtask

  initial begin
    int rr_exp [3];
    rr_exp[0] = 0;
    rr_exp[1] = 1;
    rr_exp[2] = 4;
    rst_n = 1'b0;
    clear_inputs();
    bus.out_ready_i = '0;
    model_reset();
    for (int i = 0; i < IN_N; i++) xfers[i] = 0;

    // Reset state
    #12;
    chk("reset_in_ready",   32'(bus.in_ready_o),   32'h0);
    chk("reset_out_valid",  32'(bus.out_valid_o),  32'h0);
    chk("reset_out_busy",   32'(bus.out_busy_o),   32'h0);
    chk("reset_out_in_sel", 32'(bus.out_in_sel_o), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Input 2: 3-flit packet to output 3
    bus.out_ready_i = 5'h1F;
    set_in(2, 1'b1, 1'b1, 1'b0, 3);
    #1;
    chk("t1_busy_c0", 32'(bus.out_busy_o[3]), 32'h0);
    tick();
    set_in(2, 1'b1, 1'b0, 1'b0, 3);
    #1;
    chk("t1_busy_c1",  32'(bus.out_busy_o[3]), 32'h1);
    chk("t1_sel_c1",   32'(sel_of(3)),        32'h2);
    chk("t1_ready_c1", 32'(bus.in_ready_o[2]), 32'h1);
    tick();
    #1;
    chk("t1_ready_c2", 32'(bus.in_ready_o[2]), 32'h1);
    tick();
    set_in(2, 1'b1, 1'b0, 1'b1, 3);
    #1;
    chk("t1_ready_c3", 32'(bus.in_ready_o[2]), 32'h1);
    tick();
    clear_inputs();
    #1;
    chk("t1_busy_c4", 32'(bus.out_busy_o[3]), 32'h0);
    tick();

    // Inputs 0, 1, 4 contend for output 0 with single-flit packets
    set_in(0, 1'b1, 1'b1, 1'b1, 0);
    set_in(1, 1'b1, 1'b1, 1'b1, 0);
    set_in(4, 1'b1, 1'b1, 1'b1, 0);
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c % 2 == 1) begin
        chk("rr_busy",  32'(bus.out_busy_o[0]), 32'h1);
        chk("rr_owner", 32'(sel_of(0)),        32'(rr_exp[((c - 1) / 2) % 3]));
      end else begin
        chk("rr_gap", 32'(bus.out_busy_o[0]), 32'h0);
      end
      tick();
    end
    clear_inputs();
    #1;
    tick();

    // Input 1 to output 2 with a 5-cycle backpressure stall and a valid gap
    for (int i = 0; i < IN_N; i++) xfers[i] = 0;
    set_in(1, 1'b1, 1'b1, 1'b0, 2);
    #1;
    tick();
    set_in(1, 1'b1, 1'b0, 1'b0, 2);
    #1;
    chk("stall_ready_pre", 32'(bus.in_ready_o[1]), 32'h1);
    tick();
    bus.out_ready_i[2] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_ready", 32'(bus.in_ready_o[1]), 32'h0);
      chk("stall_busy",  32'(bus.out_busy_o[2]), 32'h1);
      tick();
    end
    bus.out_ready_i[2] = 1'b1;
    bus.in_valid_i[1] = 1'b0;
    #1;
    chk("gap_valid", 32'(bus.out_valid_o[2]), 32'h0);
    chk("gap_busy",  32'(bus.out_busy_o[2]),  32'h1);
    tick();
    set_in(1, 1'b1, 1'b0, 1'b0, 2);
    #1;
    tick();
    set_in(1, 1'b1, 1'b0, 1'b1, 2);
    #1;
    tick();
    clear_inputs();
    #1;
    chk("stall_release", 32'(bus.out_busy_o[2]), 32'h0);
    chk("stall_flits",   32'(xfers[1]),          32'd3);
    tick();

    // Concurrent packets: input 0 -> output 1, input 3 -> output 4
    set_in(0, 1'b1, 1'b1, 1'b0, 1);
    set_in(3, 1'b1, 1'b1, 1'b0, 4);
    #1;
    tick();
    set_in(0, 1'b1, 1'b0, 1'b0, 1);
    set_in(3, 1'b1, 1'b0, 1'b0, 4);
    #1;
    chk("conc_busy",  32'(bus.out_busy_o & 5'b10010), 32'(5'b10010));
    chk("conc_sel1",  32'(sel_of(1)),                 32'h0);
    chk("conc_sel4",  32'(sel_of(4)),                 32'h3);
    chk("conc_ready", 32'(bus.in_ready_o),            32'(5'b01001));
    tick();
    set_in(0, 1'b1, 1'b0, 1'b1, 1);
    set_in(3, 1'b1, 1'b0, 1'b1, 4);
    #1;
    tick();
    clear_inputs();
    #1;
    chk("conc_done", 32'(bus.out_busy_o), 32'h0);
    tick();

    // Out-of-range code and an orphan body flit are never served
    set_in(2, 1'b1, 1'b1, 1'b0, 7);
    set_in(4, 1'b1, 1'b0, 1'b0, 0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bad_ready", 32'(bus.in_ready_o), 32'h0);
      chk("bad_busy",  32'(bus.out_busy_o), 32'h0);
      tick();
    end
    clear_inputs();

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      bus.in_valid_i  = 5'($urandom);
      bus.in_head_i   = 5'($urandom);
      bus.in_tail_i   = 5'($urandom);
      bus.out_ready_i = 5'($urandom) | 5'($urandom);
      for (int i = 0; i < IN_N; i++) bus.in_out_sel_i[i*OW +: OW] = OW'($urandom_range(0, 7));
      #1;
      tick();
    end
    clear_inputs();
    bus.out_ready_i = 5'h1F;
    for (int c = 0; c < 4; c++) begin
      #1;
      tick();
    end

    // Reset pulsed mid-packet, then a contended grant
    set_in(2, 1'b1, 1'b1, 1'b0, 3);
    #1;
    tick();
    set_in(2, 1'b1, 1'b0, 1'b0, 3);
    #1;
    chk("mid_busy", 32'(bus.out_busy_o[3]), 32'h1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_in_ready",   32'(bus.in_ready_o),   32'h0);
    chk("arst_out_valid",  32'(bus.out_valid_o),  32'h0);
    chk("arst_out_busy",   32'(bus.out_busy_o),   32'h0);
    chk("arst_out_in_sel", 32'(bus.out_in_sel_o), 32'h0);
    @(posedge clk);
    #1;
    chk("arst_hold_ready", 32'(bus.in_ready_o), 32'h0);
    rst_n = 1'b1;
    clear_inputs();
    set_in(0, 1'b1, 1'b1, 1'b0, 3);
    set_in(4, 1'b1, 1'b1, 1'b0, 3);
    #1;
    tick();
    #1;
    chk("post_rst_busy",   32'(bus.out_busy_o[3]), 32'h1);
    chk("post_rst_winner", 32'(sel_of(3)),         32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
